// File: rtl/reg_arb_pkg.sv
// Shared types for the register-port arbiter: FSM state encoding and grant id width.
package reg_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;
  localparam int GRANT_W = 2;
endpackage

// File: rtl/reg_access_arbiter_if.sv
// Requester-side command/response bundle; master = requesters, slave = arbiter.
interface reg_access_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32
) ();
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;

  modport master (
    output req_valid, req_write, req_lock, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );
  modport slave (
    input  req_valid, req_write, req_lock, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx,
  output logic               any
);
  always_comb begin
    logic [IW-1:0] i;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    i   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      i = IW'((int'(ptr) + k) % NUM_REQ);
      if (!any && req[i]) begin
        any    = 1'b1;
        gnt[i] = 1'b1;
        idx    = i;
      end
    end
  end
endmodule

// File: rtl/reg_access_arbiter.sv
// Shares the register file port between NUM_REQ requesters: round-robin grant,
// one transaction in flight, optional lock to keep multi-word sequences atomic.
module reg_access_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  reg_access_arbiter_if.slave  req_if,
  output logic [ADDR_W-1:0]    reg_addr,
  output logic [DATA_W-1:0]    reg_wdata,
  output logic                 reg_write,
  output logic                 reg_read,
  input  logic [DATA_W-1:0]    reg_rdata,
  output logic [GRANT_W-1:0]   grant_id,
  output logic                 busy
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [1:0] LAT_M1 = 2'(READ_LAT - 1);

  arb_state_e             state_q, state_d;
  logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
  logic                   lock_q, lock_d;
  logic                   lock_req_q, lock_req_d;
  logic                   wr_q, wr_d;
  logic [1:0]             cnt_q, cnt_d;
  logic [GRANT_W-1:0]     grant_id_q, grant_id_d;
  logic [ADDR_W-1:0]      reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0]      reg_wdata_q, reg_wdata_d;
  logic                   reg_write_q, reg_write_d;
  logic                   reg_read_q, reg_read_d;
  logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]      rsp_rdata_q, rsp_rdata_d;

  logic [NUM_REQ-1:0][ADDR_W-1:0] addr_arr;
  logic [NUM_REQ-1:0][DATA_W-1:0] wdata_arr;
  logic [NUM_REQ-1:0]             own_mask, cand;
  logic [NUM_REQ-1:0]             pick_gnt;
  logic [IW-1:0]                  pick_idx;
  logic                           pick_any;

  assign addr_arr  = req_if.req_addr;
  assign wdata_arr = req_if.req_wdata;
  assign own_mask  = NUM_REQ'(1) << grant_id_q;
  // While locked only the previous owner is eligible.
  assign cand      = lock_q ? (req_if.req_valid & own_mask) : req_if.req_valid;

  rr_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req (cand),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign req_if.req_ready = (rst_n && state_q == IDLE) ? pick_gnt : '0;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lock_d      = lock_q;
    lock_req_d  = lock_req_q;
    wr_d        = wr_q;
    cnt_d       = cnt_q;
    grant_id_d  = grant_id_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_write_d = 1'b0;
    reg_read_d  = 1'b0;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: if (pick_any) begin
        wr_d        = req_if.req_write[pick_idx];
        lock_req_d  = req_if.req_lock[pick_idx];
        reg_addr_d  = addr_arr[pick_idx];
        reg_wdata_d = wdata_arr[pick_idx];
        reg_write_d = req_if.req_write[pick_idx];
        reg_read_d  = !req_if.req_write[pick_idx];
        grant_id_d  = GRANT_W'(pick_idx);
        rr_ptr_d    = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
        state_d     = ISSUE;
      end
      ISSUE: begin
        if (wr_q) begin
          rsp_valid_d = own_mask;
          rsp_rdata_d = '0;
          state_d     = RESP;
        end else begin
          cnt_d   = LAT_M1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          rsp_valid_d = own_mask;
          rsp_rdata_d = reg_rdata;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP: begin
        lock_d  = lock_req_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      lock_q      <= 1'b0;
      lock_req_q  <= 1'b0;
      wr_q        <= 1'b0;
      cnt_q       <= '0;
      grant_id_q  <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_write_q <= 1'b0;
      reg_read_q  <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_q      <= lock_d;
      lock_req_q  <= lock_req_d;
      wr_q        <= wr_d;
      cnt_q       <= cnt_d;
      grant_id_q  <= grant_id_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_write_q <= reg_write_d;
      reg_read_q  <= reg_read_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign reg_addr         = reg_addr_q;
  assign reg_wdata        = reg_wdata_q;
  assign reg_write        = reg_write_q;
  assign reg_read         = reg_read_q;
  assign grant_id         = grant_id_q;
  assign busy             = (state_q != IDLE);
  assign req_if.rsp_valid = rsp_valid_q;
  assign req_if.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_reg_access_arbiter.sv
// Scoreboard bench: main DUT (READ_LAT=1) plus a READ_LAT=3 instance for latency checks.
module tb_reg_access_arbiter;
  localparam int LA = 1;
  localparam int LB = 3;

  typedef struct { logic wr; logic lock; logic [7:0] addr; logic [31:0] data; } cmd_t;
  typedef struct { int id; logic [31:0] rdata; int due; } rsp_exp_t;
  typedef struct { logic wr; logic [7:0] addr; logic [31:0] wdata; int due; } stb_exp_t;

  logic clk, rst_n;
  logic [7:0]  a_reg_addr, b_reg_addr;
  logic [31:0] a_reg_wdata, b_reg_wdata, a_reg_rdata, b_reg_rdata;
  logic        a_reg_write, a_reg_read, b_reg_write, b_reg_read;
  logic [1:0]  a_grant, b_grant;
  logic        a_busy, b_busy;

  reg_access_arbiter_if #(.NUM_REQ(2), .ADDR_W(8), .DATA_W(32)) a_if ();
  reg_access_arbiter_if #(.NUM_REQ(2), .ADDR_W(8), .DATA_W(32)) b_if ();

  reg_access_arbiter #(.NUM_REQ(2), .ADDR_W(8), .DATA_W(32), .READ_LAT(LA)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req_if(a_if),
    .reg_addr(a_reg_addr), .reg_wdata(a_reg_wdata), .reg_write(a_reg_write),
    .reg_read(a_reg_read), .reg_rdata(a_reg_rdata), .grant_id(a_grant), .busy(a_busy));

  reg_access_arbiter #(.NUM_REQ(2), .ADDR_W(8), .DATA_W(32), .READ_LAT(LB)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req_if(b_if),
    .reg_addr(b_reg_addr), .reg_wdata(b_reg_wdata), .reg_write(b_reg_write),
    .reg_read(b_reg_read), .reg_rdata(b_reg_rdata), .grant_id(b_grant), .busy(b_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] dflt(int i);
    return (i == 23) ? 32'h5631_3030 : (32'h5A5A_0000 | 32'(i));
  endfunction

  // Register file models; read data is only valid in the exact READ_LAT cycle.
  logic [31:0]       mem_a [256];
  logic [31:0]       mem_b [256];
  logic [2:0]        pv_a, pv_b;
  logic [2:0][31:0]  pd_a, pd_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= dflt(i);
      pv_a <= '0; pd_a <= '0;
    end else begin
      if (a_reg_write) mem_a[a_reg_addr] <= a_reg_wdata;
      pv_a <= {pv_a[1:0], a_reg_read};
      pd_a <= {pd_a[1:0], mem_a[a_reg_addr]};
    end
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem_b[i] <= dflt(i);
      pv_b <= '0; pd_b <= '0;
    end else begin
      if (b_reg_write) mem_b[b_reg_addr] <= b_reg_wdata;
      pv_b <= {pv_b[1:0], b_reg_read};
      pd_b <= {pd_b[1:0], mem_b[b_reg_addr]};
    end
  end
  assign a_reg_rdata = pv_a[LA-1] ? pd_a[LA-1] : 32'hDEAD_BEEF;
  assign b_reg_rdata = pv_b[LB-1] ? pd_b[LB-1] : 32'hDEAD_BEEF;

  int n_chk = 0, n_err = 0, cyc = 0;
  cmd_t     cq [2][$];
  cmd_t     cur [2];
  logic     acc [2];
  int       glog [$];
  rsp_exp_t rexp [$];
  stb_exp_t sexp [$];

  task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic step();
    rsp_exp_t r;
    stb_exp_t s;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 2; i++)
      if (a_if.req_valid[i] && a_if.req_ready[i]) begin
        acc[i] = 1'b1;
        glog.push_back(i);
        rexp.push_back('{i, cur[i].wr ? 32'h0 : mem_a[cur[i].addr], cyc + (cur[i].wr ? 2 : 2 + LA)});
        sexp.push_back('{cur[i].wr, cur[i].addr, cur[i].data, cyc + 1});
      end
    if (a_reg_write || a_reg_read) begin
      chk("one_strobe", 64'(a_reg_write & a_reg_read), 0);
      if (sexp.size() == 0) chk("unexpected_strobe", 1, 0);
      else begin
        s = sexp.pop_front();
        chk("strobe_cycle", cyc, s.due);
        chk("strobe_kind", 64'(a_reg_write), 64'(s.wr));
        chk("reg_addr", 64'(a_reg_addr), 64'(s.addr));
        if (s.wr) chk("reg_wdata", 64'(a_reg_wdata), 64'(s.wdata));
      end
    end
    if (|a_if.rsp_valid) begin
      if (rexp.size() == 0) chk("unexpected_rsp", 64'(a_if.rsp_valid), 0);
      else begin
        r = rexp.pop_front();
        chk("rsp_valid", 64'(a_if.rsp_valid), 64'(2'b01 << r.id));
        chk("rsp_rdata", 64'(a_if.rsp_rdata), 64'(r.rdata));
        chk("rsp_cycle", cyc, r.due);
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) begin a_if.req_valid[i] = 1'b0; acc[i] = 1'b0; end
      if (!a_if.req_valid[i] && cq[i].size() > 0) begin
        cur[i] = cq[i].pop_front();
        a_if.req_write[i]          = cur[i].wr;
        a_if.req_lock[i]           = cur[i].lock;
        a_if.req_addr[i*8 +: 8]    = cur[i].addr;
        a_if.req_wdata[i*32 +: 32] = cur[i].data;
        a_if.req_valid[i]          = 1'b1;
      end
    end
  endtask

  function automatic bit pending();
    return cq[0].size() > 0 || cq[1].size() > 0 || a_if.req_valid != 0 || rexp.size() > 0 || a_busy;
  endfunction

  task automatic run(int maxc);
    int n = 0;
    while (pending() && n < maxc) begin step(); n++; end
    if (pending()) chk("run_timeout", 1, 0);
  endtask

  task automatic run_until_grant(int maxc);
    int n = 0;
    while (glog.size() == 0 && n < maxc) begin step(); n++; end
    if (glog.size() == 0) chk("grant_timeout", 1, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    acc[0] = 1'b0; acc[1] = 1'b0;
    rst_n = 1'b0;
    a_if.req_valid = 2'b01; a_if.req_write = '0; a_if.req_lock = '0;
    a_if.req_addr = '0; a_if.req_wdata = '0;
    b_if.req_valid = '0; b_if.req_write = '0; b_if.req_lock = '0;
    b_if.req_addr = '0; b_if.req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(a_if.req_ready), 0);
    chk("rst_busy", 64'(a_busy), 0);
    chk("rst_grant", 64'(a_grant), 0);
    chk("rst_strobes", 64'({a_reg_write, a_reg_read}), 0);
    chk("rst_rsp_valid", 64'(a_if.rsp_valid), 0);
    chk("rst_rsp_rdata", 64'(a_if.rsp_rdata), 0);
    chk("rst_reg_addr", 64'(a_reg_addr), 0);
    chk("rst_b_busy", 64'(b_busy), 0);
    a_if.req_valid = '0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single write then single read
    cq[0].push_back('{1'b1, 1'b0, 8'd24, 32'h0000_001F});
    run(50);
    cq[1].push_back('{1'b0, 1'b0, 8'd23, 32'h0});
    run(50);
    chk("rdata_hold", 64'(a_if.rsp_rdata), 64'h5631_3030);
    chk("last_grant", 64'(a_grant), 1);

    // contention: alternating grants
    glog.delete();
    for (int i = 0; i < 4; i++) begin
      cq[0].push_back('{1'b1, 1'b0, 8'(40 + i), 32'(100 + i)});
      cq[1].push_back('{1'b1, 1'b0, 8'(50 + i), 32'(200 + i)});
    end
    run(200);
    chk("contention_count", glog.size(), 8);
    for (int i = 0; i < glog.size(); i++) chk("contention_order", glog[i], i % 2);

    // lock: req1 pair stays atomic while req0 waits
    glog.delete();
    cq[1].push_back('{1'b1, 1'b1, 8'd14, 32'h0000_1414});
    cq[1].push_back('{1'b1, 1'b0, 8'd15, 32'h0000_1515});
    run_until_grant(20);
    cq[0].push_back('{1'b1, 1'b0, 8'd20, 32'h0000_2020});
    run(100);
    chk("lock_count", glog.size(), 3);
    if (glog.size() == 3) begin
      chk("lock_g0", glog[0], 1);
      chk("lock_g1", glog[1], 1);
      chk("lock_g2", glog[2], 0);
    end
    chk("mem_15", 64'(mem_a[15]), 64'h1515);

    // reset during WAIT of a read
    glog.delete();
    cq[0].push_back('{1'b0, 1'b0, 8'd23, 32'h0});
    run_until_grant(20);
    step();
    chk("pre_rst_busy", 64'(a_busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(a_busy), 0);
    chk("mid_rst_strobes", 64'({a_reg_write, a_reg_read}), 0);
    chk("mid_rst_rsp", 64'(a_if.rsp_valid), 0);
    chk("mid_rst_grant", 64'(a_grant), 0);
    chk("mid_rst_addr", 64'(a_reg_addr), 0);
    rexp.delete(); sexp.delete();
    a_if.req_valid = '0; acc[0] = 1'b0; acc[1] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post_rst_quiet", 64'(a_if.rsp_valid), 0);
    end
    glog.delete();
    cq[0].push_back('{1'b1, 1'b0, 8'd30, 32'hCAFE_0030});
    cq[1].push_back('{1'b0, 1'b0, 8'd23, 32'h0});
    run(100);
    chk("post_rst_count", glog.size(), 2);
    if (glog.size() == 2) begin
      chk("post_rst_g0", glog[0], 0);
      chk("post_rst_g1", glog[1], 1);
    end

    // READ_LAT=3 instance: read addr 1
    b_if.req_write[0] = 1'b0;
    b_if.req_addr[7:0] = 8'd1;
    b_if.req_valid[0] = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!b_if.req_ready[0] && k < 10);
    chk("lat3_accept", 64'(b_if.req_ready[0]), 1);
    @(posedge clk);
    #1;
    b_if.req_valid[0] = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (b_reg_read) chk("lat3_strobe_cycle", k, 1);
    end while (!b_if.rsp_valid[0] && k < 20);
    chk("lat3_rsp_delay", k, 5);
    chk("lat3_rdata", 64'(b_if.rsp_rdata), 64'h5A5A_0001);
    @(negedge clk);
    chk("lat3_rsp_pulse", 64'(b_if.rsp_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
